// File: rtl/spn_pkg.sv
// Shared definitions for the SPN block cipher datapath: block type, control states,
// and a reference form of the bit permutation for users outside the round controller.
package spn_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int NUM_ROUNDS = 31;
  localparam int RK_IDX_W   = 6;

  typedef logic [BLOCK_SIZE-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // Bit i lands at (i*SIZE/4) mod (SIZE-1); the top bit stays put.
  function automatic block_t perm_layer(block_t d);
    block_t p;
    p = '0;
    for (int i = 0; i < BLOCK_SIZE-1; i++)
      p[(i*BLOCK_SIZE/4) % (BLOCK_SIZE-1)] = d[i];
    p[BLOCK_SIZE-1] = d[BLOCK_SIZE-1];
    return p;
  endfunction

endpackage

// File: rtl/spn_perm_layer.sv
// Fixed bit permutation of the SPN round: pure wiring, no logic.
module spn_perm_layer #(
  parameter int SIZE = 64
) (
  input  logic [SIZE-1:0] d_i,
  output logic [SIZE-1:0] p_o
);

  // gcd(SIZE/4, SIZE-1) == 1 for the supported widths, so this is a bijection.
  for (genvar i = 0; i < SIZE-1; i++) begin : g_bit
    assign p_o[(i*SIZE/4) % (SIZE-1)] = d_i[i];
  end
  assign p_o[SIZE-1] = d_i[SIZE-1];

endmodule

// File: rtl/spn_round_ctrl.sv
// Iterative round sequencer: holds the cipher state and round counter, drives the shared
// substitution layer each round, and handshakes one block at a time with the host.
module spn_round_ctrl
  import spn_pkg::*;
#(
  parameter int SIZE   = BLOCK_SIZE,
  parameter int ROUNDS = NUM_ROUNDS,
  parameter int RW     = RK_IDX_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_block,
  output logic [RW-1:0]   rk_idx,
  input  logic [SIZE-1:0] rk,
  output logic [SIZE-1:0] sbox_in,
  input  logic [SIZE-1:0] sbox_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_block,
  output logic            busy
);

  localparam logic [RW-1:0] LAST_RND  = RW'(ROUNDS);
  localparam logic [RW-1:0] FIRST_RND = RW'(1);

  ctrl_state_e     state_q, state_d;
  logic [SIZE-1:0] st_q, st_d;
  logic [RW-1:0]   round_q, round_d;
  logic [SIZE-1:0] perm_out;

  spn_perm_layer #(.SIZE(SIZE)) u_perm (
    .d_i (sbox_out),
    .p_o (perm_out)
  );

  // The counter already sits at ROUNDS+1 in FINAL, so it doubles as the key index
  // and naturally holds its last value through DONE and IDLE.
  assign rk_idx    = round_q;
  assign sbox_in   = st_q ^ rk;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ROUND) || (state_q == FINAL);
  assign out_block = st_q;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_block;
          round_d = FIRST_RND;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d    = perm_out;
        round_d = round_q + 1'b1;
        if (round_q == LAST_RND) state_d = FINAL;
      end
      FINAL: begin
        st_d    = st_q ^ rk;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      round_q <= FIRST_RND;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      round_q <= round_d;
    end
  end

endmodule
